aes_decrypt_core: RTL and testbench
===================================

// Module: aes_decrypt_core
// PURPOSE
//  AES-128 decryption engine sitting directly downstream of the Avalon-MM AES register interface.
//  Consumes key (regs 0-3), ciphertext (regs 4-7) and start (reg 14); produces plaintext (regs 8-11) and done (reg 15).
//  Iterative datapath: one inverse-round operation per clock, sequenced by an FSM.
//  Reuses existing codebase leaf modules: KeyExpansion (combinational, 128b key -> 1408b schedule) and InvSubBytes (combinational 8b lookup, 16 instances).
// PARAMETERS
//  KEY_WAIT   2   cycles spent in KEYWAIT letting the schedule settle before capture (legal range 1..15)
// PORTS
//  CLK          in   1    system clock; all state updates on rising edge
//  RESET_N      in   1    asynchronous, active-low reset
//  AES_START    in   1    level; 1 = request decryption (mirrors start register)
//  AES_KEY      in   128  cipher key; byte 0 = bits [127:120]
//  AES_MSG_ENC  in   128  ciphertext; same byte order as AES_KEY
//  AES_MSG_DEC  out  128  plaintext result register
//  AES_DONE     out  1    1 = AES_MSG_DEC valid for the current request
//  AES_BUSY     out  1    1 in every state except IDLE and DONE
// BEHAVIOUR
//  Reset (RESET_N low, any time, including mid-operation): FSM -> IDLE; AES_MSG_DEC=0, AES_DONE=0, AES_BUSY=0;
//   state, key and round-counter registers cleared; no partial result is ever written out.
//  State layout: 128b column-major, byte i = bits [127-8i -: 8]; column c = bytes 4c..4c+3.
//  Round key r (0..10) = schedule[1407-128r -: 128]; KeyExpansion input = latched key register, not AES_KEY.
//  FSM states: IDLE, KEYWAIT, ARK_INIT, ISR, ISB, ARK, IMC, DONE.
//  IDLE: on edge with AES_START=1 -> latch AES_KEY and AES_MSG_ENC into internal registers; load wait counter; -> KEYWAIT.
//  KEYWAIT: count KEY_WAIT cycles; on last cycle capture 1408b schedule into register; -> ARK_INIT.
//  ARK_INIT: state ^= rk10; round counter = 9; -> ISR.
//  ISR: inverse shift rows; row r rotated right by r bytes; -> ISB.
//  ISB: state = InvSubBytes on all 16 bytes; -> ARK.
//  ARK: state ^= rk[round]; round counter >= 1 -> IMC; round counter = 0 -> DONE, same edge writes AES_MSG_DEC.
//  IMC: per column InvMixColumns, coefficients {0e,0b,0d,09}, GF(2^8) polynomial 0x11B, built from xtime chains;
//   round counter -= 1; -> ISR.
//  Sequence: ARK_INIT, 9 x (ISR,ISB,ARK,IMC), then ISR,ISB,ARK(rk0) = 40 operation cycles.
//  Latency: AES_DONE rises exactly KEY_WAIT+40 cycles after the edge that sampled AES_START=1 in IDLE
//   (42 with default parameter).
//  DONE: AES_DONE=1, AES_MSG_DEC held; stay while AES_START=1; AES_START=0 -> IDLE, AES_DONE cleared on that edge.
//  AES_START dropping mid-operation: ignored; operation completes, enters DONE, leaves on the next edge
//   (AES_DONE one-cycle pulse).
//  AES_KEY / AES_MSG_ENC changes after the start edge: no effect on the running operation.
//  AES_MSG_DEC changes only on the final ARK edge; retains last result through IDLE and new requests until overwritten.
//  Back-to-back: new request needs AES_START low for at least one cycle (DONE->IDLE) before re-asserting.
//  AES_BUSY is registered alongside FSM state; AES_DONE and AES_BUSY are never both 1.
//  Undefined state encodings recover to IDLE.
// TESTING
//  FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, START=1
//   -> DEC=00112233445566778899aabbccddeeff, DONE at cycle 42.
//  FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32
//   -> DEC=3243f6a8885a308d313198a2e0370734.
//  Change AES_KEY/AES_MSG_ENC to all-ones at cycle 5 of the C.1 run -> C.1 plaintext still produced at cycle 42.
//  Assert RESET_N low at cycle 20 of a run -> DEC=0, DONE=0, BUSY=0 immediately; after a restart the C.1 result is correct.
//  Drop START at cycle 10 -> DONE high for exactly one cycle at cycle 42, then IDLE; DEC holds the C.1 plaintext.
//  Hold START high after DONE, then drop, then raise again with vector B -> DONE clears, second result is B,
//   latency is 42 again.

Source files
------------

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption core: one inverse-round operation per clock, FSM sequenced.
// Contains the shared GF(2^8) helpers plus the KeyExpansion and InvSubBytes leaves.

package aes_decrypt_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 by an addition chain; 0 maps to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] v;
    v = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    return gf_inv(v);
  endfunction

  // Word i of the schedule lands at bits [1407-32i -: 32], so round key r is words 4r..4r+3.
  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] sched;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    sched = '0;
    for (int i = 0; i < 44; i++) sched[1407-32*i -: 32] = w[i];
    return sched;
  endfunction

endpackage

module KeyExpansion (
  input  logic [127:0]  key,
  output logic [1407:0] schedule
);
  import aes_decrypt_pkg::*;

  assign schedule = expand_key(key);
endmodule

module InvSubBytes (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  import aes_decrypt_pkg::*;

  assign out_byte = inv_sbox(in_byte);
endmodule

module aes_decrypt_core #(
  parameter int KEY_WAIT = 2
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_ENC,
  output logic [127:0] AES_MSG_DEC,
  output logic         AES_DONE,
  output logic         AES_BUSY
);
  import aes_decrypt_pkg::*;

  typedef enum logic [2:0] {IDLE, KEYWAIT, ARK_INIT, ISR, ISB, ARK, IMC, DONE} fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   dec_q, dec_d;
  logic [1407:0]  sched_q, sched_d;
  logic [3:0]     round_q, round_d;
  logic [3:0]     wait_q, wait_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic [1407:0]  sched_comb;
  logic [127:0]   isb_out;
  logic [127:0]   rk [0:10];

  KeyExpansion u_key_exp (
    .key      (key_q),
    .schedule (sched_comb)
  );

  for (genvar g = 0; g < 16; g++) begin : g_isb
    InvSubBytes u_isb (
      .in_byte  (state_q[127-8*g -: 8]),
      .out_byte (isb_out[127-8*g -: 8])
    );
  end

  for (genvar r = 0; r < 11; r++) begin : g_rk
    assign rk[r] = sched_q[1407-128*r -: 128];
  end

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  // Coefficients 09/0b/0d/0e are assembled from the x2/x4/x8 xtime chain of each byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [0:3];
    logic [7:0] m9 [0:3];
    logic [7:0] mb [0:3];
    logic [7:0] md [0:3];
    logic [7:0] me [0:3];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    dec_d   = dec_q;
    sched_d = sched_q;
    round_d = round_q;
    wait_d  = wait_q;
    done_d  = done_q;
    unique case (fsm_q)
      IDLE: begin
        if (AES_START) begin
          key_d   = AES_KEY;
          state_d = AES_MSG_ENC;
          wait_d  = 4'(KEY_WAIT - 1);
          fsm_d   = KEYWAIT;
        end
      end
      KEYWAIT: begin
        if (wait_q == 4'd0) begin
          sched_d = sched_comb;
          fsm_d   = ARK_INIT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ARK_INIT: begin
        state_d = state_q ^ rk[10];
        round_d = 4'd9;
        fsm_d   = ISR;
      end
      ISR: begin
        state_d = inv_shift_rows(state_q);
        fsm_d   = ISB;
      end
      ISB: begin
        state_d = isb_out;
        fsm_d   = ARK;
      end
      ARK: begin
        state_d = state_q ^ rk[round_q];
        if (round_q == 4'd0) begin
          dec_d  = state_q ^ rk[0];
          done_d = 1'b1;
          fsm_d  = DONE;
        end else begin
          fsm_d = IMC;
        end
      end
      IMC: begin
        state_d = inv_mix_columns(state_q);
        round_d = round_q - 4'd1;
        fsm_d   = ISR;
      end
      DONE: begin
        if (!AES_START) begin
          done_d = 1'b0;
          fsm_d  = IDLE;
        end
      end
      default: begin
        done_d = 1'b0;
        fsm_d  = IDLE;
      end
    endcase
    // Busy tracks the state being entered so it is registered in step with the FSM.
    busy_d = !(fsm_d == IDLE || fsm_d == DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      dec_q   <= '0;
      sched_q <= '0;
      round_q <= 4'd0;
      wait_q  <= 4'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      sched_q <= sched_d;
      round_q <= round_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign AES_MSG_DEC = dec_q;
  assign AES_DONE    = done_q;
  assign AES_BUSY    = busy_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Randomised and FIPS-197 vector bench for aes_decrypt_core with a byte-level AES
// reference model and a transaction-level timing model checked every cycle.

module tb_aes_decrypt_core;

  localparam int KW = 2;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [127:0] ct;
  logic [127:0] dec;
  logic         done;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  bit [7:0] sb  [256];
  bit [7:0] isb [256];

  logic [127:0] m_dec;
  logic [127:0] m_result;
  logic         m_done;
  logic         m_busy;
  int           m_cnt;

  aes_decrypt_core #(.KEY_WAIT(KW)) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .AES_START   (start),
    .AES_KEY     (key),
    .AES_MSG_ENC (ct),
    .AES_MSG_DEC (dec),
    .AES_DONE    (done),
    .AES_BUSY    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit [7:0] rl8(bit [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic bit [7:0] gmul(bit [7:0] a, bit [7:0] b);
    bit [7:0] p;
    bit       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box via the multiply-by-3 / divide-by-3 walk over the field, then inverted by lookup.
  task automatic build_tables();
    bit [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q ^= 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic bit [127:0] model_decrypt(bit [127:0] k, bit [127:0] c);
    bit [7:0]   w [176];
    bit [7:0]   s [16];
    bit [7:0]   t [16];
    bit [7:0]   a [4];
    bit [7:0]   tmp;
    bit [7:0]   rc;
    bit [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) a[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tmp  = a[0];
        a[0] = sb[a[1]] ^ rc;
        a[1] = sb[a[2]];
        a[2] = sb[a[3]];
        a[3] = sb[tmp];
        rc   = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ a[j];
    end
    for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ w[160+i];
    for (int round = 9; round >= 0; round--) begin
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          t[row+4*col] = s[row + 4*((col - row + 4) % 4)];
      for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ w[16*round+i];
      if (round > 0) begin
        for (int col = 0; col < 4; col++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*col+j];
          s[4*col+0] = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b) ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
          s[4*col+1] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e) ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
          s[4*col+2] = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09) ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
          s[4*col+3] = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d) ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Transaction view: a request sampled in idle yields done KW+40 edges later; done holds until start drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dec  <= '0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_dec  <= m_result;
      end
      m_cnt <= m_cnt - 1;
    end else if (m_done) begin
      if (!start) m_done <= 1'b0;
    end else if (start) begin
      m_busy   <= 1'b1;
      m_cnt    <= KW + 40;
      m_result <= model_decrypt(key, ct);
    end
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("cycle dec", dec, m_dec);
      check_output("cycle done", 128'(done), 128'(m_done));
      check_output("cycle busy", 128'(busy), 128'(m_busy));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input string name, input logic [127:0] k, input logic [127:0] c,
                                input logic [127:0] exp_pt, input int corrupt_at, input int drop_at);
    int cycle;
    key   = k;
    ct    = c;
    start = 1'b1;
    tick(1);
    cycle = 0;
    while (!done && cycle < 100) begin
      tick(1);
      cycle++;
      if (cycle == corrupt_at) begin
        key = '1;
        ct  = '1;
      end
      if (cycle == drop_at) start = 1'b0;
    end
    check_output({name, " latency"}, 128'(cycle), 128'(KW + 40));
    check_output({name, " plaintext"}, dec, exp_pt);
  endtask

  initial begin
    logic [127:0] rk, rc;
    build_tables();
    rst_n = 1'b1;
    start = 1'b0;
    key   = '0;
    ct    = '0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    tick(2);
    check_output("reset dec", dec, '0);
    check_output("reset done", 128'(done), 128'(0));
    check_output("reset busy", 128'(busy), 128'(0));
    check_output("model c1", model_decrypt(C1_KEY, C1_CT), C1_PT);
    check_output("model b", model_decrypt(B_KEY, B_CT), B_PT);
    rst_n = 1'b1;
    tick(1);

    apply_stimulus("c1", C1_KEY, C1_CT, C1_PT, 0, 0);
    tick(3);
    check_output("done held", 128'(done), 128'(1));
    start = 1'b0;
    tick(1);
    check_output("done cleared", 128'(done), 128'(0));
    check_output("dec retained", dec, C1_PT);
    apply_stimulus("b", B_KEY, B_CT, B_PT, 0, 0);
    start = 1'b0;
    tick(1);

    apply_stimulus("c1 inputs changed", C1_KEY, C1_CT, C1_PT, 5, 0);
    start = 1'b0;
    tick(1);

    apply_stimulus("c1 start dropped", C1_KEY, C1_CT, C1_PT, 0, 10);
    tick(1);
    check_output("pulse done", 128'(done), 128'(0));
    check_output("pulse busy", 128'(busy), 128'(0));
    check_output("pulse dec", dec, C1_PT);

    key   = C1_KEY;
    ct    = C1_CT;
    start = 1'b1;
    tick(21);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_output("midrun reset dec", dec, '0);
    check_output("midrun reset done", 128'(done), 128'(0));
    check_output("midrun reset busy", 128'(busy), 128'(0));
    tick(2);
    rst_n = 1'b1;
    tick(1);
    apply_stimulus("c1 after reset", C1_KEY, C1_CT, C1_PT, 0, 0);
    start = 1'b0;
    tick(1);

    for (int i = 0; i < 6; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = {$urandom(), $urandom(), $urandom(), $urandom()};
      apply_stimulus("random", rk, rc, model_decrypt(rk, rc), 0, int'($urandom_range(0, 41)));
      start = 1'b0;
      tick(1 + int'($urandom_range(0, 2)));
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
